axi_lite_master_ctrl: RTL and testbench

//  AXI-Lite initiator that turns single-beat commands from local control logic into AXI-Lite

---
 rtl/axil_pkg.sv | 27 ++
 rtl/axil_if.sv | 34 +++
 rtl/axil_watchdog.sv | 40 ++++
 rtl/axi_lite_master_ctrl.sv | 140 ++++++++++++++
 tb/tb_axi_lite_master_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_pkg.sv
// axil_pkg: shared AXI-Lite definitions for the master controller slice.
//   axil_resp_e      - AXI response encoding (bresp/rresp)
//   axil_mst_state_e - master controller FSM states
//   is_busy()        - true while a transaction is in flight on the bus
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axil_resp_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } axil_mst_state_e;

  function automatic logic is_busy(input axil_mst_state_e s);
    return (s == WR_REQ) || (s == WR_RESP) || (s == RD_REQ) || (s == RD_RESP);
  endfunction

endpackage

// File: rtl/axil_if.sv
// AXI_LITE: AXI4-Lite signal bundle.
//   master modport drives aw*/w*/ar*, bready, rready; slave modport the reverse.
interface AXI_LITE #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_watchdog.sv
// axil_watchdog: transaction watchdog for axi_lite_master_ctrl.
// Built only when AXIL_MASTER_TIMEOUT_EN is defined.
//   clk_i, rstn_i - clock, asynchronous active-low reset
//   clear_i       - command accept: restarts the count and clears the flag
//   run_i         - a transaction is in flight this cycle
//   timeout_o     - sticky flag, set once TIMEOUT_CYCLES in-flight cycles were counted
`ifdef AXIL_MASTER_TIMEOUT_EN
module axil_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clear_i,
  input  logic run_i,
  output logic timeout_o
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q;
  logic          flag_q;

  // Counter saturates at LIMIT; flag rises on the edge that completes the
  // LIMIT-th in-flight cycle and stays up until the next accept.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else if (run_i && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == LIMIT - CW'(1)) flag_q <= 1'b1;
    end
  end

  assign timeout_o = flag_q;
endmodule
`endif

// File: rtl/axi_lite_master_ctrl.sv
// axi_lite_master_ctrl: single-outstanding AXI-Lite initiator.
// Turns one-beat local commands into AXI-Lite reads/writes and returns data/response.
//   clk_i, rstn_i       - clock, asynchronous active-low reset
//   cmd_valid_i/ready_o - command handshake; cmd_write_i, cmd_addr_i, cmd_wdata_i payload
//   rsp_valid_o/ready_i - response handshake; rsp_rdata_o (0 for writes), rsp_resp_o
//   timeout_o           - watchdog flag; only active when AXIL_MASTER_TIMEOUT_EN is defined
//   axil                - AXI_LITE master port
// All AXI valid/ready outputs are registered.
module axi_lite_master_ctrl
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic [1:0]            rsp_resp_o,
  output logic                  timeout_o,
  AXI_LITE.master               axil
);
  axil_mst_state_e       state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  axil_resp_e            resp_q;
  logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                  cmd_accept;

  assign cmd_accept = cmd_valid_i && (state_q == IDLE);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= OKAY;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            addr_q <= cmd_addr_i;
            if (cmd_write_i) begin
              wdata_q   <= cmd_wdata_i;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_REQ;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          // A channel whose valid already dropped has completed; a channel
          // handshaking on this edge completes now.
          if (awvalid_q && axil.awready) awvalid_q <= 1'b0;
          if (wvalid_q && axil.wready)   wvalid_q  <= 1'b0;
          if ((!awvalid_q || axil.awready) && (!wvalid_q || axil.wready)) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axil.bvalid) begin
            resp_q   <= axil_resp_e'(axil.bresp);
            rdata_q  <= '0;
            bready_q <= 1'b0;
            state_q  <= RSP;
          end
        end
        RD_REQ: begin
          if (axil.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (axil.rvalid) begin
            resp_q   <= axil_resp_e'(axil.rresp);
            rdata_q  <= axil.rdata;
            rready_q <= 1'b0;
            state_q  <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o  = (state_q == IDLE);
  assign rsp_valid_o  = (state_q == RSP);
  assign rsp_rdata_o  = rdata_q;
  assign rsp_resp_o   = resp_q;

  assign axil.awaddr  = addr_q;
  assign axil.araddr  = addr_q;
  assign axil.wdata   = wdata_q;
  assign axil.wstrb   = '1;
  assign axil.awvalid = awvalid_q;
  assign axil.wvalid  = wvalid_q;
  assign axil.bready  = bready_q;
  assign axil.arvalid = arvalid_q;
  assign axil.rready  = rready_q;

`ifdef AXIL_MASTER_TIMEOUT_EN
  axil_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .clear_i   (cmd_accept),
    .run_i     (is_busy(state_q)),
    .timeout_o (timeout_o)
  );
`else
  logic unused_accept;
  assign unused_accept = cmd_accept;
  assign timeout_o     = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_master_ctrl.sv
// Testbench for axi_lite_master_ctrl with a small AXI-Lite responder model
// whose ready/valid timing is programmable from the stimulus sequence.
// The timeout scenario runs only when AXIL_MASTER_TIMEOUT_EN is defined.
module tb_axi_lite_master_ctrl;
  import axil_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        timeout;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  AXI_LITE #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axil ();

  axi_lite_master_ctrl #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_write_i (cmd_write),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_resp_o  (rsp_resp),
    .timeout_o   (timeout),
    .axil        (axil)
  );

  // ---------------- responder model ----------------
  int          aw_dly = 0, w_dly = 0;
  int          aw_wait, w_wait;
  logic        b_stall = 1'b0, r_stall = 1'b0;
  logic [1:0]  rresp_cfg = 2'b00;
  logic        aw_got, w_got, b_pend, r_pend;
  logic [31:0] aw_addr_s, w_data_s, rd_addr_s;
  logic [31:0] mem [0:15];
  logic        aw_hs, w_hs, ar_hs, wr_fire;
  logic [31:0] eff_addr, eff_data;

  assign axil.awready = axil.awvalid && (aw_wait >= aw_dly);
  assign axil.wready  = axil.wvalid && (w_wait >= w_dly);
  assign axil.arready = axil.arvalid;
  assign axil.bresp   = 2'b00;

  assign aw_hs    = axil.awvalid && axil.awready;
  assign w_hs     = axil.wvalid && axil.wready;
  assign ar_hs    = axil.arvalid && axil.arready;
  assign wr_fire  = (aw_got || aw_hs) && (w_got || w_hs);
  assign eff_addr = aw_got ? aw_addr_s : axil.awaddr;
  assign eff_data = w_got ? w_data_s : axil.wdata;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_wait    <= 0;
      w_wait     <= 0;
      aw_got     <= 1'b0;
      w_got      <= 1'b0;
      b_pend     <= 1'b0;
      r_pend     <= 1'b0;
      aw_addr_s  <= '0;
      w_data_s   <= '0;
      rd_addr_s  <= '0;
      axil.bvalid <= 1'b0;
      axil.rvalid <= 1'b0;
      axil.rdata  <= '0;
      axil.rresp  <= 2'b00;
    end else begin
      aw_wait <= (axil.awvalid && !axil.awready) ? aw_wait + 1 : 0;
      w_wait  <= (axil.wvalid && !axil.wready) ? w_wait + 1 : 0;
      if (wr_fire) begin
        mem[eff_addr[5:2]] <= eff_data;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        if (b_stall) b_pend <= 1'b1;
        else         axil.bvalid <= 1'b1;
      end else begin
        if (aw_hs) begin aw_got <= 1'b1; aw_addr_s <= axil.awaddr; end
        if (w_hs)  begin w_got  <= 1'b1; w_data_s  <= axil.wdata;  end
      end
      if (b_pend && !b_stall) begin axil.bvalid <= 1'b1; b_pend <= 1'b0; end
      if (axil.bvalid && axil.bready) axil.bvalid <= 1'b0;

      if (ar_hs) begin
        if (r_stall) begin
          r_pend    <= 1'b1;
          rd_addr_s <= axil.araddr;
        end else begin
          axil.rvalid <= 1'b1;
          axil.rdata  <= mem[axil.araddr[5:2]];
          axil.rresp  <= rresp_cfg;
        end
      end
      if (r_pend && !r_stall) begin
        axil.rvalid <= 1'b1;
        axil.rdata  <= mem[rd_addr_s[5:2]];
        axil.rresp  <= rresp_cfg;
        r_pend      <= 1'b0;
      end
      if (axil.rvalid && axil.rready) axil.rvalid <= 1'b0;
    end
  end

  // ---------------- bus activity monitor ----------------
  int aw_cyc = 0, w_cyc = 0, ar_cyc = 0, b_hs_cnt = 0;
  always @(posedge clk) begin
    if (rstn) begin
      if (axil.awvalid) aw_cyc <= aw_cyc + 1;
      if (axil.wvalid)  w_cyc  <= w_cyc + 1;
      if (axil.arvalid) ar_cyc <= ar_cyc + 1;
      if (axil.bvalid && axil.bready) b_hs_cnt <= b_hs_cnt + 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command for one cycle; returns in the cycle after acceptance (T1).
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    chk("cmd_ready_before_issue", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Waits for rsp_valid for at most 40 cycles; returns cycles waited.
  task automatic wait_rsp(input string tag, output int n);
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    chk(tag, rsp_valid, 1'b1);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_time_limit: observed run still active expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    int aw0, w0, ar0, b0;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    #1;
    // Reset values
    chk("rst_awvalid", axil.awvalid, 1'b0);
    chk("rst_wvalid",  axil.wvalid,  1'b0);
    chk("rst_arvalid", axil.arvalid, 1'b0);
    chk("rst_bready",  axil.bready,  1'b0);
    chk("rst_rready",  axil.rready,  1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_resp", rsp_resp, 2'b00);
    chk("rst_awaddr", axil.awaddr, 32'h0);
    chk("rst_araddr", axil.araddr, 32'h0);
    chk("rst_wdata", axil.wdata, 32'h0);
    tick();
    rstn = 1'b1;
    tick();
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);

    // 1. Zero-wait write
    aw0 = aw_cyc; w0 = w_cyc; b0 = b_hs_cnt;
    issue(1'b1, 32'h4, 32'hDEADBEEF);
    chk("t1_awvalid_T1", axil.awvalid, 1'b1);
    chk("t1_wvalid_T1", axil.wvalid, 1'b1);
    chk("t1_awaddr", axil.awaddr, 32'h4);
    chk("t1_wdata", axil.wdata, 32'hDEADBEEF);
    chk("t1_cmd_ready_busy", cmd_ready, 1'b0);
    tick();
    chk("t1_awvalid_T2", axil.awvalid, 1'b0);
    chk("t1_wvalid_T2", axil.wvalid, 1'b0);
    chk("t1_bready_T2", axil.bready, 1'b1);
    chk("t1_rsp_valid_T2", rsp_valid, 1'b0);
    tick();
    chk("t1_rsp_valid_T3", rsp_valid, 1'b1);
    chk("t1_resp", rsp_resp, 2'b00);
    chk("t1_rdata_zero", rsp_rdata, 32'h0);
    chk("t1_bready_T3", axil.bready, 1'b0);
    chk("t1_aw_cycles", aw_cyc - aw0, 1);
    chk("t1_w_cycles", w_cyc - w0, 1);
    chk("t1_b_hs", b_hs_cnt - b0, 1);
    take_rsp();
    chk("t1_rsp_valid_after", rsp_valid, 1'b0);
    chk("t1_cmd_ready_after", cmd_ready, 1'b1);

    // 2. Zero-wait read back
    ar0 = ar_cyc;
    issue(1'b0, 32'h4, 32'h0);
    chk("t2_arvalid_T1", axil.arvalid, 1'b1);
    chk("t2_araddr", axil.araddr, 32'h4);
    chk("t2_rready_T1", axil.rready, 1'b0);
    tick();
    chk("t2_arvalid_T2", axil.arvalid, 1'b0);
    chk("t2_rready_T2", axil.rready, 1'b1);
    tick();
    chk("t2_rsp_valid_T3", rsp_valid, 1'b1);
    chk("t2_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("t2_resp", rsp_resp, 2'b00);
    chk("t2_rready_T3", axil.rready, 1'b0);
    chk("t2_ar_cycles", ar_cyc - ar0, 1);
    take_rsp();

    // 3. wready delayed 3 cycles
    aw_dly = 0; w_dly = 3;
    aw0 = aw_cyc; w0 = w_cyc; b0 = b_hs_cnt;
    issue(1'b1, 32'hC, 32'hA5A50F0F);
    wait_rsp("t3_rsp_arrives", n);
    chk("t3_latency", n, 5);
    chk("t3_aw_cycles", aw_cyc - aw0, 1);
    chk("t3_w_cycles", w_cyc - w0, 4);
    chk("t3_b_hs", b_hs_cnt - b0, 1);
    chk("t3_resp", rsp_resp, 2'b00);
    take_rsp();

    // 3b. awready delayed 2 cycles, W completes first
    aw_dly = 2; w_dly = 0;
    aw0 = aw_cyc; w0 = w_cyc; b0 = b_hs_cnt;
    issue(1'b1, 32'h10, 32'h0BADF00D);
    wait_rsp("t3b_rsp_arrives", n);
    chk("t3b_latency", n, 4);
    chk("t3b_aw_cycles", aw_cyc - aw0, 3);
    chk("t3b_w_cycles", w_cyc - w0, 1);
    chk("t3b_b_hs", b_hs_cnt - b0, 1);
    take_rsp();
    aw_dly = 0;
    issue(1'b0, 32'h10, 32'h0);
    wait_rsp("t3b_rd_arrives", n);
    chk("t3b_rd_latency", n, 2);
    chk("t3b_rd_data", rsp_rdata, 32'h0BADF00D);
    take_rsp();
    issue(1'b0, 32'hC, 32'h0);
    wait_rsp("t3_rd_arrives", n);
    chk("t3_rd_data", rsp_rdata, 32'hA5A50F0F);
    take_rsp();

    // 4. SLVERR read, response back-pressured for 5 cycles
    rresp_cfg = 2'b10;
    issue(1'b0, 32'h4, 32'h0);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_rsp_valid_held", rsp_valid, 1'b1);
      chk("t4_resp_slverr", rsp_resp, 2'b10);
      chk("t4_rdata_stable", rsp_rdata, 32'hDEADBEEF);
      chk("t4_cmd_ready_low", cmd_ready, 1'b0);
      tick();
    end
    take_rsp();
    chk("t4_cmd_ready_after", cmd_ready, 1'b1);
    chk("t4_rsp_valid_after", rsp_valid, 1'b0);
    rresp_cfg = 2'b00;

    // 5. Reset during WR_RESP
    b_stall = 1'b1;
    issue(1'b1, 32'h8, 32'h12345678);
    tick();
    chk("t5_bready_wr_resp", axil.bready, 1'b1);
    tick();
    chk("t5_bready_still", axil.bready, 1'b1);
    chk("t5_rsp_valid_wait", rsp_valid, 1'b0);
    rstn = 1'b0;
    #1;
    chk("t5_awvalid_rst", axil.awvalid, 1'b0);
    chk("t5_wvalid_rst", axil.wvalid, 1'b0);
    chk("t5_arvalid_rst", axil.arvalid, 1'b0);
    chk("t5_bready_rst", axil.bready, 1'b0);
    chk("t5_rready_rst", axil.rready, 1'b0);
    chk("t5_rsp_valid_rst", rsp_valid, 1'b0);
    chk("t5_awaddr_rst", axil.awaddr, 32'h0);
    chk("t5_wdata_rst", axil.wdata, 32'h0);
    b_stall = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("t5_cmd_ready_release", cmd_ready, 1'b1);
    chk("t5_bready_release", axil.bready, 1'b0);
    chk("t5_timeout_release", timeout, 1'b0);

`ifdef AXIL_MASTER_TIMEOUT_EN
    // 6. Watchdog: rvalid withheld
    r_stall = 1'b1;
    issue(1'b0, 32'h4, 32'h0);
    chk("t6_timeout_T1", timeout, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    chk("t6_timeout_T16", timeout, 1'b0);
    tick();
    chk("t6_timeout_T17", timeout, 1'b1);
    chk("t6_rready_held", axil.rready, 1'b1);
    r_stall = 1'b0;
    wait_rsp("t6_late_rsp", n);
    chk("t6_late_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("t6_timeout_sticky", timeout, 1'b1);
    take_rsp();
    chk("t6_timeout_idle", timeout, 1'b1);
    issue(1'b0, 32'h4, 32'h0);
    chk("t6_timeout_cleared", timeout, 1'b0);
    wait_rsp("t6_next_rsp", n);
    take_rsp();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
